// File: rtl/lsu_bus.sv
// Load/store unit between EXU and WBU: request/response memory port with
// back-pressure, byte-lane steering, misalignment detection and load extension.
module lsu_bus #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PASS_W = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              in_ren,
    input  logic              in_wen,
    input  logic [2:0]        in_op,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [PASS_W-1:0] in_pass,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_rdata,
    output logic [PASS_W-1:0] out_pass,
    output logic [1:0]        out_fault,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_wen,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [3:0]        mem_req_wstrb,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata,
    input  logic              mem_resp_err
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HALF_W = 16;

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2, DONE = 2'd3} state_t;

    state_t state;
    state_t state_nxt;

    logic              accept;
    logic              capture;
    logic              is_mem;
    logic              sz_byte;
    logic              sz_half;
    logic              misaligned;
    logic [3:0]        lane_strb;
    logic [DATA_W-1:0] lane_data;

    logic              lat_ren;
    logic              lat_byte;
    logic              lat_half;
    logic              lat_sext;
    logic [1:0]        lat_lo;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] load_val;

    assign accept  = in_valid && (state == IDLE);
    assign capture = mem_resp_valid &&
                     (((state == REQ) && mem_req_ready) || (state == RESP));

    // Access size, alignment and store lane steering for the incoming instruction.
    always_comb begin
        is_mem     = in_ren | in_wen;
        sz_byte    = (in_op == 3'b000) || (in_ren && (in_op == 3'b100));
        sz_half    = (in_op == 3'b001) || (in_ren && (in_op == 3'b101));
        misaligned = is_mem && ((sz_half && in_addr[0]) ||
                                (!sz_byte && !sz_half && (in_addr[1:0] != 2'b00)));
        lane_strb  = 4'b1111;
        lane_data  = in_wdata;
        if (sz_byte) begin
            lane_strb = 4'b0001 << in_addr[1:0];
            lane_data = {4{in_wdata[BYTE_W-1:0]}};
        end else if (sz_half) begin
            lane_strb = 4'b0011 << in_addr[1:0];
            lane_data = {2{in_wdata[HALF_W-1:0]}};
        end
    end

    // Pick the addressed byte/half out of the response word and extend it.
    always_comb begin
        shifted  = mem_resp_rdata >> {lat_lo, 3'b000};
        load_val = shifted;
        if (lat_byte) begin
            load_val = {{(DATA_W-BYTE_W){lat_sext & shifted[BYTE_W-1]}}, shifted[BYTE_W-1:0]};
        end else if (lat_half) begin
            load_val = {{(DATA_W-HALF_W){lat_sext & shifted[HALF_W-1]}}, shifted[HALF_W-1:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (!is_mem || misaligned) ? DONE : REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_nxt = mem_resp_valid ? DONE : RESP;
                end
            end
            RESP: begin
                if (mem_resp_valid) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready      = 1'b0;
        mem_req_valid = 1'b0;
        out_valid     = 1'b0;
        case (state)
            IDLE:    in_ready      = 1'b1;
            REQ:     mem_req_valid = 1'b1;
            DONE:    out_valid     = 1'b1;
            default: ;
        endcase
    end

    // Latch the instruction at accept; fold the response in when it arrives.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_addr      <= '0;
            out_rdata     <= '0;
            out_pass      <= '0;
            out_fault     <= 2'b00;
            mem_req_addr  <= '0;
            mem_req_wen   <= 1'b0;
            mem_req_wdata <= '0;
            mem_req_wstrb <= 4'b0000;
            lat_ren       <= 1'b0;
            lat_byte      <= 1'b0;
            lat_half      <= 1'b0;
            lat_sext      <= 1'b0;
            lat_lo        <= 2'b00;
        end else begin
            if (accept) begin
                out_addr      <= in_addr;
                out_pass      <= in_pass;
                out_rdata     <= '0;
                out_fault     <= misaligned ? 2'b01 : 2'b00;
                mem_req_addr  <= {in_addr[ADDR_W-1:2], 2'b00};
                mem_req_wen   <= in_wen;
                mem_req_wdata <= lane_data;
                mem_req_wstrb <= in_wen ? lane_strb : 4'b0000;
                lat_ren       <= in_ren;
                lat_byte      <= sz_byte;
                lat_half      <= sz_half;
                lat_sext      <= ~in_op[2];
                lat_lo        <= in_addr[1:0];
            end
            if (capture) begin
                if (mem_resp_err) begin
                    out_fault <= 2'b10;
                    out_rdata <= '0;
                end else begin
                    out_rdata <= lat_ren ? load_val : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_bus.sv
// Bench for lsu_bus: directed vector table, reset/idle-response corners and
// randomized transactions against an arithmetic reference model.
module tb_lsu_bus;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned PASS_W = 40;
    localparam int unsigned NTBL   = 15;
    localparam int unsigned NRAND  = 200;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr = '0;
    logic              in_ren = 1'b0;
    logic              in_wen = 1'b0;
    logic [2:0]        in_op = 3'b000;
    logic [DATA_W-1:0] in_wdata = '0;
    logic [PASS_W-1:0] in_pass = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_rdata;
    logic [PASS_W-1:0] out_pass;
    logic [1:0]        out_fault;
    logic              mem_req_valid;
    logic              mem_req_ready = 1'b0;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_wen;
    logic [DATA_W-1:0] mem_req_wdata;
    logic [3:0]        mem_req_wstrb;
    logic              mem_resp_valid = 1'b0;
    logic [DATA_W-1:0] mem_resp_rdata = '0;
    logic              mem_resp_err = 1'b0;

    int errors = 0;
    int checks = 0;

    lsu_bus #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PASS_W(PASS_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_ren(in_ren), .in_wen(in_wen), .in_op(in_op),
        .in_wdata(in_wdata), .in_pass(in_pass),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_rdata(out_rdata), .out_pass(out_pass), .out_fault(out_fault),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .mem_resp_err(mem_resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          ren;
        bit          wen;
        logic [2:0]  op;
        logic [31:0] wdata;
        logic [39:0] pass;
        logic [31:0] mrdata;
        bit          merr;
        int          req_wait;
        int          resp_lat;
        int          out_wait;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_fault;
        bit          exp_mem;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t tbl [NTBL];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int size_of(input bit ren, input logic [2:0] op);
        case (op)
            3'b000:  return 1;
            3'b001:  return 2;
            3'b100:  return ren ? 1 : 4;
            3'b101:  return ren ? 2 : 4;
            default: return 4;
        endcase
    endfunction

    // Reference model: expected results from access size and byte arithmetic.
    function automatic vec_t predict(input vec_t v);
        int     sz;
        int     lo;
        bit     mem;
        longint val;
        longint span;
        mem  = v.ren || v.wen;
        sz   = size_of(v.ren, v.op);
        lo   = int'(v.addr % 32'd4);
        v.exp_mem   = mem && ((v.addr % 32'(sz)) == 32'd0);
        v.exp_fault = !mem ? 2'd0 : !v.exp_mem ? 2'd1 : v.merr ? 2'd2 : 2'd0;
        v.exp_rdata = '0;
        if (v.ren && v.exp_mem && !v.merr) begin
            span = longint'(1) << (8 * sz);
            val  = v.mrdata;
            val  = (val / (longint'(1) << (8 * lo))) % span;
            if (v.op < 3'b100 && sz < 4 && val >= span / 2) val = val - span;
            v.exp_rdata = 32'(val);
        end
        v.exp_strb = '0;
        if (v.wen) begin
            for (int k = 0; k < sz; k++) v.exp_strb = v.exp_strb | 4'(1 << (lo + k));
        end
        for (int i = 0; i < 4; i++) v.exp_wdata[8*i +: 8] = v.wdata[8*(i % sz) +: 8];
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        int   kind;
        kind     = int'($urandom_range(0, 2));
        v.ren    = 1'b0;
        v.wen    = 1'b0;
        v.op     = 3'($urandom_range(0, 7));
        v.addr   = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
        if (kind == 0) v.addr = $urandom;
        if (kind == 1) v.ren = 1'b1;
        if (kind == 2) begin
            v.wen = 1'b1;
            v.op  = 3'($urandom_range(0, 3));
        end
        v.wdata    = $urandom;
        v.pass     = 40'({$urandom, $urandom});
        v.mrdata   = $urandom;
        v.merr     = ($urandom_range(0, 7) == 0);
        v.req_wait = int'($urandom_range(0, 3));
        v.resp_lat = int'($urandom_range(0, 3));
        v.out_wait = int'($urandom_range(0, 2));
        return predict(v);
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Drives one instruction, plays memory and WBU, checks every cycle.
    task automatic run_txn(input vec_t v, input string name);
        bit   acc_pending = 0, accepted = 0, hs_pending = 0, hs_done = 0;
        bit   resp_given = 0, done = 0, mem_seen = 0, first_out = 0;
        int   lat = 0, pend = 0, rcnt = 0, held = 0;
        logic [31:0] exp_req_addr;
        exp_req_addr = {v.addr[31:2], 2'b00};
        for (int cyc = 0; cyc < 80 && !done; cyc++) begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            mem_resp_err   = 1'b0;
            mem_req_ready  = 1'b0;
            mem_resp_rdata = v.mrdata;
            if (cyc == 0) begin
                in_valid = 1'b1; in_addr = v.addr; in_ren = v.ren; in_wen = v.wen;
                in_op = v.op; in_wdata = v.wdata; in_pass = v.pass;
            end
            if (acc_pending) begin
                accepted = 1; acc_pending = 0; in_valid = 1'b0;
                in_addr = $urandom; in_wdata = $urandom; in_op = 3'($urandom);
                in_pass = 40'({$urandom, $urandom}); in_ren = 1'($urandom); in_wen = ~in_ren;
            end
            if (hs_pending) begin
                hs_done = 1; hs_pending = 0;
            end
            if (accepted) begin
                lat++;
                chk({name, ".in_ready_busy"}, 64'(in_ready), 64'(0));
            end else if (in_valid && in_ready) begin
                acc_pending = 1;
            end
            if (hs_done && !resp_given) begin
                rcnt++;
                if (rcnt == v.resp_lat) begin
                    mem_resp_valid = 1'b1; mem_resp_err = v.merr; resp_given = 1;
                end
            end
            if (mem_req_valid) begin
                mem_seen = 1;
                chk({name, ".req_legal"}, 64'(accepted && v.exp_mem && !hs_done), 64'(1));
                chk({name, ".req_addr"}, 64'(mem_req_addr), 64'(exp_req_addr));
                chk({name, ".req_wen"}, 64'(mem_req_wen), 64'(v.wen));
                chk({name, ".req_wstrb"}, 64'(mem_req_wstrb), 64'(v.exp_strb));
                if (v.wen) chk({name, ".req_wdata"}, 64'(mem_req_wdata), 64'(v.exp_wdata));
                pend++;
                if (pend > v.req_wait) begin
                    mem_req_ready = 1'b1; hs_pending = 1;
                    if (v.resp_lat == 0) begin
                        mem_resp_valid = 1'b1; mem_resp_err = v.merr; resp_given = 1;
                    end
                end
            end
            if (out_valid) begin
                chk({name, ".valid_after_accept"}, 64'(accepted), 64'(1));
                if (!first_out) begin
                    first_out = 1;
                    if (v.req_wait == 0 && v.resp_lat == 0)
                        chk({name, ".latency"}, 64'(lat), 64'(v.exp_mem ? 2 : 1));
                end
                chk({name, ".out_addr"}, 64'(out_addr), 64'(v.addr));
                chk({name, ".out_pass"}, 64'(out_pass), 64'(v.pass));
                chk({name, ".out_rdata"}, 64'(out_rdata), 64'(v.exp_rdata));
                chk({name, ".out_fault"}, 64'(out_fault), 64'(v.exp_fault));
                held++;
                if (held > v.out_wait) begin
                    out_ready = 1'b1; done = 1;
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s.timeout: got no WBU handshake expected one within 80 cycles", name);
            do_reset();
        end else begin
            @(negedge clk);
            out_ready = 1'b0;
            chk({name, ".valid_drop"}, 64'(out_valid), 64'(0));
            chk({name, ".in_ready_back"}, 64'(in_ready), 64'(1));
            chk({name, ".mem_traffic"}, 64'(mem_seen), 64'(v.exp_mem));
        end
    endtask

    initial begin
        tbl[0]  = '{32'h0000_1234, 1'b0, 1'b0, 3'b000, 32'h0, 40'hAB, 32'h0, 1'b0, 0, 0, 0,
                    32'h0, 2'd0, 1'b0, 4'h0, 32'h0};
        tbl[1]  = '{32'h8000_0003, 1'b1, 1'b0, 3'b000, 32'h0, 40'h11, 32'h80FF_7F01, 1'b0, 0, 0, 0,
                    32'hFFFF_FF80, 2'd0, 1'b1, 4'h0, 32'h0};
        tbl[2]  = '{32'h8000_0003, 1'b1, 1'b0, 3'b100, 32'h0, 40'h22, 32'h80FF_7F01, 1'b0, 0, 0, 0,
                    32'h0000_0080, 2'd0, 1'b1, 4'h0, 32'h0};
        tbl[3]  = '{32'h8000_0002, 1'b0, 1'b1, 3'b001, 32'hDEAD_BEEF, 40'h33, 32'h0, 1'b0, 0, 0, 0,
                    32'h0, 2'd0, 1'b1, 4'hC, 32'hBEEF_BEEF};
        tbl[4]  = '{32'h8000_0002, 1'b1, 1'b0, 3'b010, 32'h0, 40'h44, 32'h5555_5555, 1'b0, 0, 0, 0,
                    32'h0, 2'd1, 1'b0, 4'h0, 32'h0};
        tbl[5]  = '{32'h8000_0010, 1'b1, 1'b0, 3'b010, 32'h0, 40'h55, 32'h1234_5678, 1'b1, 0, 0, 0,
                    32'h0, 2'd2, 1'b1, 4'h0, 32'h0};
        tbl[6]  = '{32'h8000_0002, 1'b1, 1'b0, 3'b001, 32'h0, 40'h66, 32'h80FF_7F01, 1'b0, 0, 0, 0,
                    32'hFFFF_80FF, 2'd0, 1'b1, 4'h0, 32'h0};
        tbl[7]  = '{32'h8000_0000, 1'b1, 1'b0, 3'b101, 32'h0, 40'h77, 32'h80FF_7F01, 1'b0, 0, 0, 0,
                    32'h0000_7F01, 2'd0, 1'b1, 4'h0, 32'h0};
        tbl[8]  = '{32'h8000_0001, 1'b0, 1'b1, 3'b000, 32'h1234_5678, 40'h88, 32'h0, 1'b0, 0, 0, 0,
                    32'h0, 2'd0, 1'b1, 4'h2, 32'h7878_7878};
        tbl[9]  = '{32'h8000_0004, 1'b0, 1'b1, 3'b010, 32'hCAFE_F00D, 40'h99, 32'h0, 1'b0, 0, 0, 0,
                    32'h0, 2'd0, 1'b1, 4'hF, 32'hCAFE_F00D};
        tbl[10] = '{32'h8000_0001, 1'b0, 1'b1, 3'b001, 32'h1111_2222, 40'hAA, 32'h0, 1'b0, 0, 0, 0,
                    32'h0, 2'd1, 1'b0, 4'h0, 32'h0};
        tbl[11] = '{32'h8000_0002, 1'b1, 1'b0, 3'b000, 32'h0, 40'hBB, 32'h80FF_7F01, 1'b0, 0, 0, 0,
                    32'hFFFF_FFFF, 2'd0, 1'b1, 4'h0, 32'h0};
        tbl[12] = '{32'h8000_000C, 1'b1, 1'b0, 3'b010, 32'h0, 40'hCC, 32'h89AB_CDEF, 1'b0, 3, 2, 2,
                    32'h89AB_CDEF, 2'd0, 1'b1, 4'h0, 32'h0};
        tbl[13] = '{32'h8000_0001, 1'b1, 1'b0, 3'b011, 32'h0, 40'hDD, 32'h0, 1'b0, 0, 0, 0,
                    32'h0, 2'd1, 1'b0, 4'h0, 32'h0};
        tbl[14] = '{32'h8000_0003, 1'b0, 1'b1, 3'b000, 32'h0000_00A5, 40'hEE, 32'h0, 1'b1, 1, 1, 0,
                    32'h0, 2'd2, 1'b1, 4'h8, 32'hA5A5_A5A5};

        repeat (3) @(negedge clk);
        chk("reset.out_valid", 64'(out_valid), 64'(0));
        chk("reset.mem_req_valid", 64'(mem_req_valid), 64'(0));
        chk("reset.out_fault", 64'(out_fault), 64'(0));
        chk("reset.out_addr", 64'(out_addr), 64'(0));
        chk("reset.out_rdata", 64'(out_rdata), 64'(0));
        chk("reset.out_pass", 64'(out_pass), 64'(0));
        rst = 1'b1;
        @(negedge clk);
        chk("reset.in_ready", 64'(in_ready), 64'(1));

        // A stray error response while idle must not leak into the next result.
        mem_resp_valid = 1'b1; mem_resp_err = 1'b1; mem_resp_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_resp_valid = 1'b0; mem_resp_err = 1'b0;

        for (int i = 0; i < int'(NTBL); i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

        // Reset while a request is outstanding drops the instruction.
        @(negedge clk);
        in_valid = 1'b1; in_addr = 32'h8000_0020; in_ren = 1'b1; in_wen = 1'b0; in_op = 3'b010;
        mem_req_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst_req.in_req", 64'(mem_req_valid), 64'(1));
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req.mem_req_valid", 64'(mem_req_valid), 64'(0));
        chk("rst_req.out_valid", 64'(out_valid), 64'(0));
        chk("rst_req.in_ready", 64'(in_ready), 64'(1));
        chk("rst_req.out_addr", 64'(out_addr), 64'(0));
        rst = 1'b1;
        @(negedge clk);
        chk("rst_req.idle_after", 64'(mem_req_valid | out_valid), 64'(0));

        for (int i = 0; i < int'(NRAND); i++) run_txn(rand_vec(), $sformatf("rnd%0d", i));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
